// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath: sequences fetch (T0-T2)
// and execute (T3-T7) strobes from IR[31:27] and the CON flip-flop result.
module control_sequencer #(
    parameter int              OP_W    = 5,
    parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        con,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        RAMenable,
    output logic        read,
    output logic        write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        R15in,
    output logic        Yin,
    output logic        ZLOin,
    output logic        ZLOout,
    output logic        Cout,
    output logic        conin,
    output logic [4:0]  aluControl,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(5'b10010);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(5'b10101);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);

    state_t          state, next_state;
    logic [OP_W-1:0] opcode;
    logic            is_alu, is_mem;
    logic            unused_ir_bits;

    assign opcode         = IR[31 -: OP_W];
    assign unused_ir_bits = ^IR[31-OP_W:0];
    assign is_alu         = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                            (opcode == OP_AND) || (opcode == OP_OR);
    assign is_mem         = (opcode == OP_LD) || (opcode == OP_ST);

    // NOTE: state is updated with <= so every always_ff reader sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (!clear) state <= S_RESET;
        else        state <= next_state;
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        {PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, RAMenable, read, write} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, R15in} = '0;
        {Yin, ZLOin, ZLOout, Cout, conin} = '0;
        aluControl = 5'b00000;
        run        = (state != S_RESET) && (state != S_HALT);

        unique case (state)
            S_RESET: next_state = S_T0;
            S_T0: begin
                {PCout, MARin, IncPC} = '1;
                next_state = S_T1;
            end
            S_T1: begin
                {read, RAMenable, MDRin} = '1;
                next_state = S_T2;
            end
            S_T2: begin
                {MDRout, IRin} = '1;
                next_state = S_T3;
            end
            S_T3: begin
                next_state = S_T4;
                if (opcode == OP_JR) begin
                    {Gra, Rout, PCin} = '1;
                    next_state = S_T0;
                end else if (opcode == OP_JAL) begin
                    {PCout, R15in} = '1;
                end else if (is_alu || opcode == OP_ADDI) begin
                    {Grb, Rout, Yin} = '1;
                end else if (is_mem) begin
                    {Grb, BAout, Yin} = '1;
                end else if (opcode == OP_BR) begin
                    {Gra, Rout, conin} = '1;
                end else if (opcode == OP_HALT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T4: begin
                next_state = S_T5;
                if (opcode == OP_JAL) begin
                    {Gra, Rout, PCin} = '1;
                    next_state = S_T0;
                end else if (is_alu) begin
                    {Grc, Rout, ZLOin} = '1;
                    aluControl = 5'(opcode);
                end else if (is_mem || opcode == OP_ADDI) begin
                    {Cout, ZLOin} = '1;
                    aluControl = 5'(ALU_ADD);
                end else if (opcode == OP_BR) begin
                    {PCout, Yin} = '1;
                end else begin
                    next_state = S_T0;
                end
            end
            S_T5: begin
                next_state = S_T0;
                if (is_alu || opcode == OP_ADDI) begin
                    {ZLOout, Gra, Rin} = '1;
                end else if (is_mem) begin
                    {ZLOout, MARin} = '1;
                    next_state = S_T6;
                end else if (opcode == OP_BR) begin
                    {Cout, ZLOin} = '1;
                    aluControl = 5'(ALU_ADD);
                    next_state = S_T6;
                end
            end
            S_T6: begin
                next_state = S_T0;
                if (opcode == OP_LD) begin
                    {read, RAMenable, MDRin} = '1;
                    next_state = S_T7;
                end else if (opcode == OP_ST) begin
                    {Gra, Rout, MDRin} = '1;
                    next_state = S_T7;
                end else if (opcode == OP_BR) begin
                    ZLOout = 1'b1;
                    PCin   = con;
                end
            end
            S_T7: begin
                next_state = S_T0;
                if (opcode == OP_LD)      {MDRout, Gra, Rin} = '1;
                else if (opcode == OP_ST) {write, RAMenable} = '1;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the Mini SRC datapath.
- Sits directly upstream of DataPath and replaces hand-driven bench control: it generates every per-cycle strobe for fetch (T0–T2) and execute (T3–T7).
- Decodes IR[31:27] and uses the datapath CON flip-flop result for conditional branches.
- Supports ld, st, add, sub, and, or, addi, br, jr, jal, nop and halt.

Parameters:
- OP_W, 5, opcode width; opcode field is IR[31:32-OP_W].
- ALU_ADD, 5'b00011, aluControl code driven for all address and offset adds.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous active-low reset, sampled on rising clock.
- IR  in  32  instruction register contents from DataPath.
- con  in  1  CON_FF output (branch condition true).
- PCout, IncPC, MARin, PCin, MDRin, MDRout, IRin, RAMenable, read, write  out  1 each  memory and PC strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, R15in  out  1 each  register-select and register-transfer strobes.
- Yin, ZLOin, ZLOout, Cout, conin  out  1 each  ALU and condition strobes.
- aluControl  out  5  ALU operation select.
- run  out  1  high while executing; low in RESET and HALT.

Behaviour:
- State register updates on the rising clock edge. Outputs are combinational decode of state, IR and con; there is no output register.
- Every strobe defaults to 0 in any state that does not name it. aluControl defaults to 5'b00000.
- clear=0 at a rising edge forces RESET regardless of current state, including mid-instruction:
  - all outputs are 0 in RESET, run=0;
  - no read, write or Rin is issued in the cycle after reset.
  - RESET→T0 on the first edge with clear=1.
- Fetch, same for all opcodes:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3 on.
- Opcode map: ld 00000, st 00001, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, jr 10100, jal 10101, nop 11010, halt 11011. Any other value executes as nop.
- Execute sequences (each step is one cycle; after the last step, next state is T0):
  - jr: T3 Gra, Rout, PCin.
  - jal: T3 PCout, R15in (R15←PC+1); T4 Gra, Rout, PCin.
  - add/sub/and/or: T3 Grb, Rout, Yin; T4 Grc, Rout, ZLOin, aluControl=opcode; T5 ZLOout, Gra, Rin.
  - addi: T3 Grb, Rout, Yin; T4 Cout, ZLOin, aluControl=ALU_ADD; T5 ZLOout, Gra, Rin.
  - ld: T3 Grb, BAout, Yin; T4 Cout, ZLOin, aluControl=ALU_ADD; T5 ZLOout, MARin; T6 read, RAMenable, MDRin; T7 MDRout, Gra, Rin.
  - st: T3–T5 as ld; T6 Gra, Rout, MDRin (read=0); T7 write, RAMenable.
  - br: T3 Gra, Rout, conin; T4 PCout, Yin; T5 Cout, ZLOin, aluControl=ALU_ADD; T6 ZLOout always, PCin=con (con sampled during T6).
  - nop / undefined: T3 no strobes.
  - halt: T3→HALT.
- HALT: all outputs 0, run=0, held until clear=0.
- Instruction lengths in cycles, fetch included: jr 4, nop 4, jal 5, ALU 6, addi 6, br 7, ld 8, st 8.
- Invariants:
  - at most one bus driver (PCout, MDRout, ZLOout, Rout, Cout) is high in any cycle;
  - read and write are never both high.

Test Plan:
- clear=0 for 2 edges then 1 → all outputs 0 and run=0 during reset; run=1 and T0 strobes (PCout, MARin, IncPC) on the first cycle after.
- IR=0xA0800000 (jr, ra=R1) after fetch → T3 asserts Gra, Rout, PCin; the next cycle is T0 again (4-cycle instruction).
- IR=jal R2 → T3 PCout+R15in, T4 Gra+Rout+PCin; no other strobes.
- br with con=1 then with con=0 → T6 ZLOout=1 both times; PCin=1 only when con=1; T0 follows.
- ld (opcode 00000) → strobes in order over T3–T7, aluControl=00011 in T4, Rin only in T7; st → write+RAMenable only in T7.
- halt → run falls after T3 and no strobes for 10 cycles; clear=0 during a ld T6 → next cycle is RESET with read=0, then a clean fetch.
